// File: rtl/card_rng_pkg.sv
`default_nettype none
// ============================================================================
// Module      : card_rng_pkg
// Description : Shared types and constants for the card_rng block.
//               - state_e   : draw controller states (IDLE, DRAW, DONE)
//               - TAPS_*    : Galois LFSR tap masks for right-shift operation
//               - lfsr_taps : selects the tap mask for a given LFSR width
//               - to_bcd    : splits a 0..99 value into {tens, ones}
// Revision    : 1.0 - initial release
// ============================================================================
package card_rng_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DRAW = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [31:0] TAPS_8  = 32'h0000_00B8;
  localparam logic [31:0] TAPS_16 = 32'h0000_B400;
  localparam logic [31:0] TAPS_24 = 32'h00E1_0000;
  localparam logic [31:0] TAPS_32 = 32'h8020_0003;

  function automatic logic [31:0] lfsr_taps(input int w);
    case (w)
      8:       return TAPS_8;
      16:      return TAPS_16;
      24:      return TAPS_24;
      32:      return TAPS_32;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [7:0] to_bcd(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

endpackage
`default_nettype wire

// File: rtl/key_debounce.sv
`default_nettype none
// ============================================================================
// Module      : key_debounce
// Description : Synchronises a raw active-low key, qualifies it after
//               DEB_CYCLES consecutive low cycles and emits a single press
//               pulse per press; the key must return high to re-arm.
// Ports       : clk_i   - clock
//               rst_ni  - asynchronous active-low reset
//               req_ni  - raw asynchronous key, active low
//               press_o - one-cycle press pulse
// Revision    : 1.0 - initial release
// ============================================================================
module key_debounce #(
  parameter int DEB_CYCLES = 1000000
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic req_ni,
  output logic press_o
);

  localparam int              CNT_W   = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_CYCLES - 1);

  logic             sync1_q, sync2_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             fired_q, fired_d;

  // The pulse fires in the cycle the counter sits at its terminal value while
  // the key is still low, so DEB_CYCLES synchronised-low cycles are required.
  // fired_q blocks further pulses until the key is released.
  always_comb begin
    press_o = !sync2_q && (cnt_q == CNT_MAX) && !fired_q;
    if (sync2_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_MAX) begin
      cnt_d = cnt_q;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    fired_d = !sync2_q && (fired_q || press_o);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      cnt_q   <= '0;
      fired_q <= 1'b0;
    end else begin
      sync1_q <= req_ni;
      sync2_q <= sync1_q;
      cnt_q   <= cnt_d;
      fired_q <= fired_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/card_rng.sv
`default_nettype none
// ============================================================================
// Module      : card_rng
// Description : Debounced key-triggered card draw. A free-running Galois LFSR
//               is sampled by rejection into MIN_VAL..MAX_VAL; after
//               MAX_TRIES rejections the sample is folded into range instead.
// Ports       : CLOCK_50   - clock
//               resetn     - asynchronous active-low reset
//               req_n      - raw active-low draw key
//               seed_load  - load seed into the LFSR (honoured in IDLE only)
//               seed       - LFSR seed value
//               busy       - high while a draw is in progress (DRAW, DONE)
//               card_valid - one-cycle pulse with a new card
//               card_value - last card drawn
//               card_tens  - BCD tens digit of card_value
//               card_ones  - BCD ones digit of card_value
// Revision    : 1.0 - initial release
// ============================================================================
module card_rng #(
  parameter int LFSR_W     = 16,
  parameter int VAL_W      = 4,
  parameter int MIN_VAL    = 1,
  parameter int MAX_VAL    = 11,
  parameter int DEB_CYCLES = 1000000,
  parameter int MAX_TRIES  = 8,
  parameter int LFSR_SEED  = 1
) (
  input  logic              CLOCK_50,
  input  logic              resetn,
  input  logic              req_n,
  input  logic              seed_load,
  input  logic [LFSR_W-1:0] seed,
  output logic              busy,
  output logic              card_valid,
  output logic [VAL_W-1:0]  card_value,
  output logic [3:0]        card_tens,
  output logic [3:0]        card_ones
);

  import card_rng_pkg::*;

  localparam int                SPAN    = MAX_VAL - MIN_VAL + 1;
  localparam int                TRY_W   = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;
  localparam logic [LFSR_W-1:0] TAPS    = LFSR_W'(lfsr_taps(LFSR_W));
  localparam logic [VAL_W:0]    SPAN_V  = (VAL_W + 1)'(SPAN);
  localparam logic [VAL_W-1:0]  SPAN_LO = VAL_W'(SPAN);
  localparam logic [VAL_W-1:0]  MIN_V   = VAL_W'(MIN_VAL);
  localparam logic [7:0]        BCD_RST = to_bcd(MIN_VAL);
  localparam logic [TRY_W-1:0]  TRY_END = TRY_W'(MAX_TRIES - 1);

  generate
    if ((2 * SPAN < (1 << VAL_W)) || (MAX_VAL >= (1 << VAL_W)) || (MAX_VAL > 99) ||
        (MIN_VAL > MAX_VAL) || (MIN_VAL < 0) || (VAL_W > LFSR_W) || (MAX_TRIES < 1) ||
        (DEB_CYCLES < 1) || (LFSR_SEED == 0) ||
        !((LFSR_W == 8) || (LFSR_W == 16) || (LFSR_W == 24) || (LFSR_W == 32))) begin : g_bad_params
      $error("card_rng: illegal parameter combination");
    end
  endgenerate

  logic              press;
  state_e            state_q;
  logic [LFSR_W-1:0] lfsr_q, lfsr_d;
  logic [TRY_W-1:0]  try_q;
  logic [VAL_W-1:0]  sample;
  logic              in_range, accept;
  logic [VAL_W-1:0]  value_d;
  logic [7:0]        bcd_d;

  key_debounce #(
    .DEB_CYCLES(DEB_CYCLES)
  ) u_deb (
    .clk_i  (CLOCK_50),
    .rst_ni (resetn),
    .req_ni (req_n),
    .press_o(press)
  );

  always_comb begin
    lfsr_d = lfsr_q >> 1;
    if (lfsr_q[0]) begin
      lfsr_d = (lfsr_q >> 1) ^ TAPS;
    end
    // Escape the all-zero lock-up state of the LFSR.
    if (lfsr_q == '0) begin
      lfsr_d = LFSR_W'(1);
    end
    if ((state_q == IDLE) && seed_load) begin
      lfsr_d = (seed == '0) ? LFSR_W'(1) : seed;
    end
  end

  // Rejection sampling; the fold path relies on 2*SPAN >= 2^VAL_W so that
  // sample-SPAN always lands inside the span.
  always_comb begin
    sample   = lfsr_q[VAL_W-1:0];
    in_range = ({1'b0, sample} < SPAN_V);
    accept   = in_range || (try_q == TRY_END);
    value_d  = in_range ? (sample + MIN_V) : (sample - SPAN_LO + MIN_V);
    bcd_d    = to_bcd(int'(value_d));
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state_q    <= IDLE;
      lfsr_q     <= LFSR_W'(LFSR_SEED);
      try_q      <= '0;
      busy       <= 1'b0;
      card_valid <= 1'b0;
      card_value <= MIN_V;
      card_tens  <= BCD_RST[7:4];
      card_ones  <= BCD_RST[3:0];
    end else begin
      lfsr_q     <= lfsr_d;
      card_valid <= 1'b0;
      case (state_q)
        IDLE: begin
          if (press) begin
            state_q <= DRAW;
            try_q   <= '0;
            busy    <= 1'b1;
          end
        end
        DRAW: begin
          if (accept) begin
            state_q    <= DONE;
            card_valid <= 1'b1;
            card_value <= value_d;
            card_tens  <= bcd_d[7:4];
            card_ones  <= bcd_d[3:0];
          end else begin
            try_q <= try_q + TRY_W'(1);
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy    <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/card_rng.md
CARD_RNG -- requirements
Module: card_rng

Interface
REQ-001 SHALL have parameter LFSR_W, default 16, LFSR width; legal values 8, 16, 24, 32.
REQ-002 SHALL have parameter VAL_W, default 4, width of the raw sample and of card_value.
REQ-003 SHALL have parameter MIN_VAL, default 1, smallest card value.
REQ-004 SHALL have parameter MAX_VAL, default 11, largest card value.
REQ-005 SHALL have parameter DEB_CYCLES, default 1000000, number of stable-low clock cycles that qualify a key press.
REQ-006 SHALL have parameter MAX_TRIES, default 8, rejection attempts before fallback mapping.
REQ-007 SHALL have parameter LFSR_SEED, default 1, non-zero LFSR reset value.
REQ-008 CLOCK_50  in  1  sole clock; all flops rise on posedge.
REQ-009 resetn  in  1  asynchronous, active-low reset.
REQ-010 req_n  in  1  raw, active-low, asynchronous draw key (1 = released).
REQ-011 seed_load  in  1  synchronous seed load strobe.
REQ-012 seed  in  LFSR_W  seed value.
REQ-013 busy  out  1  high in DRAW and DONE.
REQ-014 card_valid  out  1  one-cycle pulse, new card present.
REQ-015 card_value  out  VAL_W  last drawn value, held between draws.
REQ-016 card_tens, card_ones  out  4 each  BCD split of card_value, registered with it.

Function
REQ-017 req_n SHALL pass a 2-flop synchroniser before any other use.
REQ-018 Debounce counter SHALL clear whenever synchronised req_n is 1 and increment while it is 0, saturating at DEB_CYCLES-1.
REQ-019 Exactly one press pulse SHALL be generated on the cycle the counter reaches DEB_CYCLES-1; there is no further pulse until req_n returns to 1.
REQ-020 LFSR SHALL step every cycle as a Galois right shift: if lsb=1, next = (lfsr>>1) XOR TAPS[LFSR_W]; otherwise next = lfsr>>1.
REQ-021 If the LFSR ever holds 0, next value SHALL be 1.
REQ-022 seed_load=1 in IDLE SHALL load seed, or 1 if seed=0, instead of stepping; seed_load is ignored in DRAW and DONE.
REQ-023 FSM states: IDLE, DRAW, DONE. IDLE->DRAW on press pulse. DRAW->DONE on accept. DONE->IDLE unconditionally after one cycle.
REQ-024 A press pulse arriving in DRAW or DONE SHALL be dropped, not queued.
REQ-025 In DRAW, each cycle: sample s = lfsr[VAL_W-1:0]; SPAN = MAX_VAL-MIN_VAL+1; accept if s < SPAN, giving value = s+MIN_VAL.
REQ-026 If s >= SPAN, DRAW SHALL retry on the next cycle; the try counter clears on entry to DRAW.
REQ-027 On the MAX_TRIES-th consecutive rejection, DRAW SHALL accept value = s-SPAN+MIN_VAL.
REQ-028 Elaboration SHALL fail unless 2*SPAN >= 2^VAL_W, MAX_VAL < 2^VAL_W, MAX_VAL <= 99, and MIN_VAL <= MAX_VAL.
REQ-029 card_value, card_tens and card_ones SHALL update on the DRAW->DONE edge; card_valid SHALL be 1 only in DONE.
REQ-030 Latency from press pulse to card_valid SHALL be 2 to MAX_TRIES+1 cycles.
REQ-031 busy SHALL be 1 in DRAW and DONE and 0 in IDLE.

Reset
REQ-032 resetn=0 SHALL set: state=IDLE, lfsr=LFSR_SEED, debounce counter=0, synchroniser flops=1, card_value=MIN_VAL, BCD outputs set to match MIN_VAL, card_valid=0, busy=0.
REQ-033 Reset asserted in DRAW or DONE SHALL abort the draw with no card_valid pulse.

Structure
REQ-034 Package card_rng_pkg SHALL hold the FSM state enum and TAPS constants: 8:'hB8, 16:'hB400, 24:'hE10000, 32:'h80200003.
REQ-035 Debounce logic (synchroniser, counter, one-shot) SHALL be a separate sub-module named key_debounce, parameterised by DEB_CYCLES.

Verification (DEB_CYCLES=4, default other parameters)
REQ-036 Bounce: req_n low 3 cycles, high, low 3 cycles -> no card_valid, busy stays 0.
REQ-037 Hold: req_n low 1000 cycles -> exactly one card_valid pulse, 2 to 9 cycles after the debounce pulse.
REQ-038 Seed: seed_load=1 with seed=0 in IDLE -> lfsr=16'h0001 next cycle; then with seed=16'h0001 -> lfsr=16'h0001, and next step = 16'hB400.
REQ-039 Range: 10000 draws with varied press timing -> every card_value in 1..11, all 11 values seen, card_tens/card_ones correct (for example 10 -> tens 1, ones 0).
REQ-040 Busy drop: second press pulse forced during DRAW -> single card_valid, no second draw.
REQ-041 Mid-draw reset: resetn=0 in DRAW -> next edge shows IDLE, card_value=1, card_valid=0, lfsr=16'h0001.
